// File: rtl/dv_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// dv_seq_ctrl_if
// Signal bundle between the DUT power/reset sequencer and its environment.
//
// Parameters:
//   N          number of DUT channels
//
// Signals:
//   go          environment -> sequencer, level request to run; low aborts
//   chan_en     environment -> sequencer, per-channel participation mask
//   dut_active  environment -> sequencer, per-channel DUT out of reset
//   cmds_done   environment -> sequencer, per-channel stimulus complete
//   test_done   environment -> sequencer, per-channel checking complete
//   vdd_en      sequencer -> environment, supply ramping or on
//   vdd_good    sequencer -> environment, supply safe
//   dut_nreset  sequencer -> environment, DUT reset (active-low)
//   start       sequencer -> environment, per-channel sticky start level
//   finish      sequencer -> environment, one-cycle pulse at end of test
//   timeout     sequencer -> environment, sticky watchdog-expiry flag
//   state       sequencer -> environment, current FSM state encoding
//
// Modports:
//   master  environment side (drives requests, observes sequencer)
//   slave   sequencer side
// -----------------------------------------------------------------------------
interface dv_seq_ctrl_if #(
    parameter int N = 4
);
    logic         go;
    logic [N-1:0] chan_en;
    logic [N-1:0] dut_active;
    logic [N-1:0] cmds_done;
    logic [N-1:0] test_done;
    logic         vdd_en;
    logic         vdd_good;
    logic         dut_nreset;
    logic [N-1:0] start;
    logic         finish;
    logic         timeout;
    logic [2:0]   state;

    modport master (
        output go, chan_en, dut_active, cmds_done, test_done,
        input  vdd_en, vdd_good, dut_nreset, start, finish, timeout, state
    );

    modport slave (
        input  go, chan_en, dut_active, cmds_done, test_done,
        output vdd_en, vdd_good, dut_nreset, start, finish, timeout, state
    );
endinterface

// File: rtl/dv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dv_seq_ctrl
// Power-up / reset / run / drain sequencer for a multi-channel DUT harness.
// Walks IDLE -> RAMP -> SETTLE -> HOLD -> RUN -> DRAIN -> DONE, driving the
// supply enables and the DUT reset, releasing per-channel start levels, and
// pulsing finish once at the end. Dropping go returns to IDLE from anywhere.
//
// Optional feature macro: DV_SEQ_WATCHDOG_EN
//   defined   -> a RUN watchdog moves to TIMEOUT after TIMEOUT_CYCLES RUN
//                cycles without completion and raises the sticky timeout flag
//   undefined -> no watchdog counter, timeout tied low, TIMEOUT unreachable
//
// Parameters:
//   N, CW, RAMP_CYCLES, SETTLE_CYCLES, HOLD_CYCLES, DRAIN_CYCLES, TIMEOUT_CYCLES
//
// Ports:
//   clk     clock, rising edge
//   nreset  asynchronous active-low reset
//   bus     dv_seq_ctrl_if.slave: go/chan_en/dut_active/cmds_done/test_done in,
//           vdd_en/vdd_good/dut_nreset/start/finish/timeout/state out
// -----------------------------------------------------------------------------
module dv_seq_ctrl #(
    parameter int N              = 4,
    parameter int CW             = 16,
    parameter int RAMP_CYCLES    = 20,
    parameter int SETTLE_CYCLES  = 20,
    parameter int HOLD_CYCLES    = 40,
    parameter int DRAIN_CYCLES   = 500,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic         clk,
    input  logic         nreset,
    dv_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAMP    = 3'd1,
        S_SETTLE  = 3'd2,
        S_HOLD    = 3'd3,
        S_RUN     = 3'd4,
        S_DRAIN   = 3'd5,
        S_DONE    = 3'd6,
        S_TIMEOUT = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  start_q, start_d;
    logic          vdd_en_q, vdd_en_d;
    logic          vdd_good_q, vdd_good_d;
    logic          dut_nreset_q, dut_nreset_d;
    logic          finish_q, finish_d;

    logic          all_done;
    logic          phase_end;

    // Channels left out of the mask count as complete.
    assign all_done  = &((bus.cmds_done & bus.test_done) | ~bus.chan_en);
    // A load of 1 (or a degenerate 0) ends the phase after one cycle.
    assign phase_end = (cnt_q <= CW'(1));

`ifdef DV_SEQ_WATCHDOG_EN
    logic [CW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;
    logic          wd_expired;

    // wd_q counts completed RUN cycles; this is the last one allowed.
    assign wd_expired = (wd_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_d  = start_q;
`ifdef DV_SEQ_WATCHDOG_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif

        // Start levels accumulate from RUN onward and only clear in IDLE.
        if (state_q >= S_RUN) begin
            start_d = start_q | (bus.chan_en & bus.dut_active);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d = S_RAMP;
                    cnt_d   = CW'(RAMP_CYCLES);
                end
            end
            S_RAMP: begin
                if (phase_end) begin
                    state_d = S_SETTLE;
                    cnt_d   = CW'(SETTLE_CYCLES);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SETTLE: begin
                if (phase_end) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(HOLD_CYCLES);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
`ifdef DV_SEQ_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RUN: begin
                // Completion is checked first so it wins a same-cycle expiry.
                if (all_done) begin
                    state_d = S_DRAIN;
                    cnt_d   = CW'(DRAIN_CYCLES);
                end
`ifdef DV_SEQ_WATCHDOG_EN
                else if (wd_expired) begin
                    state_d   = S_TIMEOUT;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + CW'(1);
                end
`endif
            end
            S_DRAIN: begin
                if (phase_end) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                // DONE and TIMEOUT park here until go drops.
            end
        endcase

        // Abort overrides everything above.
        if ((state_q != S_IDLE) && !bus.go) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            start_d = '0;
`ifdef DV_SEQ_WATCHDOG_EN
            wd_d      = '0;
            timeout_d = 1'b0;
`endif
        end

        // Outputs are decoded from the next state and registered so the
        // supply/reset pins change in the same cycle as state and never glitch.
        vdd_en_d     = (state_d != S_IDLE);
        vdd_good_d   = (state_d >= S_SETTLE);
        dut_nreset_d = (state_d >= S_RUN);
        finish_d     = (state_d != state_q) &&
                       ((state_d == S_DONE) || (state_d == S_TIMEOUT));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            start_q      <= '0;
            vdd_en_q     <= 1'b0;
            vdd_good_q   <= 1'b0;
            dut_nreset_q <= 1'b0;
            finish_q     <= 1'b0;
`ifdef DV_SEQ_WATCHDOG_EN
            wd_q         <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            vdd_en_q     <= vdd_en_d;
            vdd_good_q   <= vdd_good_d;
            dut_nreset_q <= dut_nreset_d;
            finish_q     <= finish_d;
`ifdef DV_SEQ_WATCHDOG_EN
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign bus.state      = state_q;
    assign bus.vdd_en     = vdd_en_q;
    assign bus.vdd_good   = vdd_good_q;
    assign bus.dut_nreset = dut_nreset_q;
    assign bus.start      = start_q;
    assign bus.finish     = finish_q;

`ifdef DV_SEQ_WATCHDOG_EN
    assign bus.timeout = timeout_q;
`else
    // TIMEOUT_CYCLES only matters for the watchdog build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign bus.timeout        = 1'b0;
`endif

endmodule

// File: doc/dv_seq_ctrl.md
DV_SEQ_CTRL -- requirements
Module: dv_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: number of DUT channels.
REQ-002 SHALL have parameter CW, default 16: phase/watchdog counter width.
REQ-003 SHALL have parameter RAMP_CYCLES, default 20: supply-ramp phase length.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 20: supply-settle phase length.
REQ-005 SHALL have parameter HOLD_CYCLES, default 40: DUT reset-hold phase length.
REQ-006 SHALL have parameter DRAIN_CYCLES, default 500: post-completion drain length.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 5000: RUN watchdog limit.
REQ-008 SHALL have port clk, input, 1: clock, rising edge.
REQ-009 SHALL have port nreset, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have port go, input, 1: level request to run the sequence; low aborts.
REQ-011 SHALL have port chan_en, input, N: per-channel participation mask.
REQ-012 SHALL have port dut_active, input, N: per-channel DUT out of reset.
REQ-013 SHALL have port cmds_done, input, N: per-channel stimulus complete.
REQ-014 SHALL have port test_done, input, N: per-channel checking complete.
REQ-015 SHALL have port vdd_en, output, 1: supply ramping or on.
REQ-016 SHALL have port vdd_good, output, 1: supply safe.
REQ-017 SHALL have port dut_nreset, output, 1: DUT reset, active-low.
REQ-018 SHALL have port start, output, N: per-channel sticky start level.
REQ-019 SHALL have port finish, output, 1: one-cycle pulse at end of test.
REQ-020 SHALL have port timeout, output, 1: sticky watchdog-expiry flag.
REQ-021 SHALL have port state, output, 3: current FSM state encoding.

Function
REQ-022 SHALL use states IDLE=0, RAMP=1, SETTLE=2, HOLD=3, RUN=4, DRAIN=5, DONE=6, TIMEOUT=7, all registered.
REQ-023 SHALL move IDLE->RAMP on the first edge sampling go=1.
REQ-024 SHALL stay exactly RAMP_CYCLES, SETTLE_CYCLES, HOLD_CYCLES, DRAIN_CYCLES cycles in RAMP, SETTLE, HOLD, DRAIN respectively, then advance RAMP->SETTLE->HOLD->RUN and DRAIN->DONE.
REQ-025 SHALL reload a down-counter of CW bits on each phase entry; the value 1 yields a one-cycle phase.
REQ-026 SHALL drive vdd_en=1 in every state except IDLE, vdd_good=1 in SETTLE..TIMEOUT, and dut_nreset=1 in RUN..TIMEOUT.
REQ-027 SHALL, in RUN/DRAIN/DONE/TIMEOUT, set start[i] on the edge sampling chan_en[i]&dut_active[i]=1 and hold it until IDLE.
REQ-028 SHALL move RUN->DRAIN when, for every i, ((cmds_done[i]&test_done[i]) | ~chan_en[i]) is 1; chan_en=0 moves to DRAIN after one RUN cycle.
REQ-029 SHALL pulse finish for exactly one cycle on entry to DONE or TIMEOUT.
REQ-030 SHALL hold DONE/TIMEOUT until go=0.
REQ-031 SHALL, on go=0 in any non-IDLE state, enter IDLE on the next edge, clearing start, the counters and timeout.
REQ-032 SHALL ignore changes to chan_en outside RUN for the completion check.

Reset
REQ-033 SHALL, while nreset=0, asynchronously force state=IDLE, vdd_en=0, vdd_good=0, dut_nreset=0, start=0, finish=0, timeout=0, and clear all counters.
REQ-034 SHALL resume from IDLE after nreset rises, requiring go sampled 1 to restart.

Configuration
REQ-035 SHALL, with DV_SEQ_WATCHDOG_EN defined, count RUN cycles from 0; at count TIMEOUT_CYCLES without completion it enters TIMEOUT and sets timeout=1.
REQ-036 SHALL give completion priority over expiry when both occur in the same cycle (enter DRAIN).
REQ-037 SHALL, without DV_SEQ_WATCHDOG_EN, omit the watchdog counter, tie timeout to 0, and make TIMEOUT unreachable.

Verification (N=4, RAMP=4, SETTLE=4, HOLD=8, DRAIN=10, TIMEOUT=50)
REQ-038 SHALL check: go=1 sampled at edge 0 -> vdd_en=1 after edge 1, vdd_good=1 after edge 5, dut_nreset=1 after edge 17, state=4.
REQ-039 SHALL check: chan_en=0101, dut_active=1111 in RUN -> start=0101 one edge later, stays 0101.
REQ-040 SHALL check: cmds_done=test_done=0101, chan_en=0101 -> DRAIN next edge; finish pulses once 10 cycles later; state=6.
REQ-041 SHALL check (DV_SEQ_WATCHDOG_EN): done never asserted -> state=7, timeout=1, and a finish pulse 50 cycles after RUN entry.
REQ-042 SHALL check: go dropped in HOLD -> next edge state=0, vdd_en=0, dut_nreset=0, start=0.
REQ-043 SHALL check: nreset low mid-RUN -> all outputs 0 immediately without a clock edge.
